multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM sequencing the shared 16-bit CPU datapath (PC, IR, regfile, ALU, unified memory).
//  Decodes the 4-bit opcode and drives per-state datapath strobes/muxes. Waits on a memory-ready handshake.
//  Counts retired instructions and flags halt, illegal opcode and memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a memory state waits for mem_ready before bus_err (1..255)
//  CNT_W        16  width of instr_count
// PORTS
//  CLK          in   1      system clock, rising edge
//  RESET        in   1      asynchronous, active-low reset
//  op           in   4      opcode field of IR
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory has completed the current read/write this cycle
//  pc_write     out  1      load PC
//  pc_src       out  2      PC mux: 00 ALU result (PC+1), 01 ALUOut (branch target), 10 jump target
//  ir_write     out  1      load IR from memory data
//  iord         out  1      memory address mux: 0 PC, 1 ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  reg_write    out  1      regfile write enable
//  reg_dst      out  1      write register: 0 rt, 1 rd
//  mem_to_reg   out  1      write data: 0 ALUOut, 1 memory data register
//  alu_src_a    out  1      0 PC, 1 ReadData1
//  alu_src_b    out  2      00 ReadData2, 01 const 1, 10 sign-extended imm
//  alu_op       out  3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
//  state        out  3      current FSM state (debug)
//  halted       out  1      sticky: HALT executed or bus_err
//  illegal      out  1      sticky: undefined opcode decoded
//  bus_err      out  1      sticky: memory timeout
//  instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (any time, asynchronous): state=FETCH, all strobes 0, mux selects 0, alu_op=ADD, flags 0, instr_count=0.
//  Outputs are Moore (decoded from state) except strobes gated by mem_ready or zero, as noted below.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, A J, B HALT; C-F are illegal.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
//    Stays in FETCH while !mem_ready.
//    On mem_ready: ir_write=1, pc_write=1 (pc_src=00), then go to DECODE.
//  DECODE (1 cycle): alu_src_a=0, alu_src_b=10, alu_op=ADD (branch target into ALUOut).
//    R-type (0-4) and ADDI -> EXEC. LW/SW -> EXEC. BEQ/BNE -> BRANCH. J -> JUMP. HALT -> HALT.
//    Illegal opcode -> set illegal, go to FETCH (executes as NOP, not counted).
//  EXEC: alu_src_a=1.
//    R-type: alu_src_b=00, alu_op per opcode, then go to WB.
//    ADDI/LW/SW: alu_src_b=10, alu_op=ADD. ADDI -> WB; LW/SW -> MEM.
//  MEM: iord=1, mem_read=(LW) or mem_write=(SW), held until mem_ready.
//    On mem_ready: LW -> WB; SW -> FETCH (retire).
//  WB (1 cycle): reg_write=1.
//    reg_dst=1 for R-type, 0 for ADDI/LW. mem_to_reg=1 only for LW. Then go to FETCH (retire).
//  BRANCH (1 cycle): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
//    pc_write = zero for BEQ, !zero for BNE. Then go to FETCH (retire).
//  JUMP (1 cycle): pc_write=1, pc_src=10, then go to FETCH (retire).
//  HALT: all strobes 0, halted=1, counted once on entry. Absorbing until reset.
//  Retire = instr_count+1 on the transition that completes the instruction; wraps from 0xFFFF to 0.
//  Timeout: wait counter clears on entering FETCH/MEM and increments each cycle that mem_ready=0.
//    When it reaches MEM_TIMEOUT: bus_err=1, halted=1, go to HALT; strobes drop that same edge.
//  mem_ready outside FETCH/MEM is ignored. mem_ready on the first cycle of a memory state is a zero-wait access.
//  Reset mid-MEM: the write strobe drops asynchronously; no partial state is kept.
// STRUCTURE
//  Package cpu_ctrl_pkg holds:
//    state encoding (FETCH=0, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT=7),
//    opcode localparams, alu_op codes, pc_src and alu_src_b encodings.
//  Sub-module mc_opcode_decode (combinational): op -> {is_rtype, is_addi, is_lw, is_sw, is_br, is_j, is_halt,
//    is_illegal, alu_op}. Instantiated once.
//  FSM, wait counter and retire counter live in multicycle_ctrl.
// TESTING
//  1 ADD, mem_ready=1: states FETCH,DECODE,EXEC,WB (4 clk); reg_write=1, reg_dst=1 in WB; instr_count 0->1.
//  2 LW, mem_ready low 3 cycles in MEM: mem_read/iord held 4 cycles; WB with mem_to_reg=1; 5+3 clk total.
//  3 BEQ zero=1 -> pc_write=1, pc_src=01. BEQ zero=0 -> pc_write=0. BNE inverts both. Each counts 1.
//  4 op=4'hD: illegal=1, returns to FETCH after DECODE, instr_count unchanged. Then HALT: halted=1, state stuck at 7.
//  5 mem_ready=0 forever in FETCH (MEM_TIMEOUT=15): bus_err=1 and halted=1 after 15 cycles; mem_read=0 thereafter.
//  6 RESET asserted mid-SW MEM: mem_write drops before the next edge. After release: FETCH, counters=0, flags=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path.
// The state encoding is visible on the debug port, so its values are fixed.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_JUMP   = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PCS_INC    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic       is_rtype;
    logic       is_addi;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_bne;
    logic       is_j;
    logic       is_halt;
    logic       is_illegal;
    logic [2:0] alu_op;
  } dec_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode, ALU flag, memory handshake and all strobes/mux selects.
interface multicycle_ctrl_if;

  logic [3:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op
  );

endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier; also selects the ALU function used by R-type execution.
module mc_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (op)
      OP_ADD:  dec.is_rtype = 1'b1;
      OP_SUB: begin
        dec.is_rtype = 1'b1;
        dec.alu_op   = ALU_SUB;
      end
      OP_AND: begin
        dec.is_rtype = 1'b1;
        dec.alu_op   = ALU_AND;
      end
      OP_OR: begin
        dec.is_rtype = 1'b1;
        dec.alu_op   = ALU_OR;
      end
      OP_SLT: begin
        dec.is_rtype = 1'b1;
        dec.alu_op   = ALU_SLT;
      end
      OP_ADDI: dec.is_addi = 1'b1;
      OP_LW:   dec.is_lw   = 1'b1;
      OP_SW:   dec.is_sw   = 1'b1;
      OP_BEQ:  dec.is_br   = 1'b1;
      OP_BNE: begin
        dec.is_br  = 1'b1;
        dec.is_bne = 1'b1;
      end
      OP_J:    dec.is_j    = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute, waits on mem_ready with a timeout,
// counts retired instructions and keeps sticky halt/illegal/bus-error flags.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  multicycle_ctrl_if.master    bus,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [7:0]       TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur_st;
  state_t     nxt_st;
  logic [7:0] wait_cnt;
  dec_t       dec;
  ctrl_t      ctl;
  ctrl_t      ctl_o;
  logic       mem_state;
  logic       timeout;
  logic       retire;
  logic       set_illegal;

  mc_opcode_decode u_dec (
    .op  (bus.op),
    .dec (dec)
  );

  always_comb begin
    nxt_st      = cur_st;
    ctl         = '0;
    ctl.alu_op  = ALU_ADD;
    retire      = 1'b0;
    set_illegal = 1'b0;
    mem_state   = (cur_st == ST_FETCH) || (cur_st == ST_MEM);
    // Timeout fires on the cycle that would make the wait count reach MEM_TIMEOUT.
    timeout     = mem_state && !bus.mem_ready && (wait_cnt == TO_LAST);

    case (cur_st)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCS_INC;
          nxt_st       = ST_DECODE;
        end else if (timeout) begin
          nxt_st = ST_HALT;
        end
      end

      ST_DECODE: begin
        ctl.alu_src_b = SRCB_IMM;
        if (dec.is_illegal) begin
          set_illegal = 1'b1;
          nxt_st      = ST_FETCH;
        end else if (dec.is_halt) begin
          retire = 1'b1;
          nxt_st = ST_HALT;
        end else if (dec.is_br) begin
          nxt_st = ST_BRANCH;
        end else if (dec.is_j) begin
          nxt_st = ST_JUMP;
        end else begin
          nxt_st = ST_EXEC;
        end
      end

      ST_EXEC: begin
        ctl.alu_src_a = 1'b1;
        if (dec.is_rtype) begin
          ctl.alu_src_b = SRCB_REG;
          ctl.alu_op    = dec.alu_op;
          nxt_st        = ST_WB;
        end else begin
          ctl.alu_src_b = SRCB_IMM;
          nxt_st        = dec.is_addi ? ST_WB : ST_MEM;
        end
      end

      ST_MEM: begin
        ctl.iord      = 1'b1;
        ctl.mem_read  = dec.is_lw;
        ctl.mem_write = dec.is_sw;
        if (bus.mem_ready) begin
          if (dec.is_lw) begin
            nxt_st = ST_WB;
          end else begin
            retire = 1'b1;
            nxt_st = ST_FETCH;
          end
        end else if (timeout) begin
          nxt_st = ST_HALT;
        end
      end

      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = dec.is_rtype;
        ctl.mem_to_reg = dec.is_lw;
        retire         = 1'b1;
        nxt_st         = ST_FETCH;
      end

      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PCS_BRANCH;
        ctl.pc_write  = dec.is_bne ? !bus.zero : bus.zero;
        retire        = 1'b1;
        nxt_st        = ST_FETCH;
      end

      ST_JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PCS_JUMP;
        retire       = 1'b1;
        nxt_st       = ST_FETCH;
      end

      ST_HALT: nxt_st = ST_HALT;

      default: nxt_st = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_st      <= ST_FETCH;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      cur_st <= nxt_st;

      if ((nxt_st != cur_st) && ((nxt_st == ST_FETCH) || (nxt_st == ST_MEM))) begin
        wait_cnt <= 8'd0;
      end else if (mem_state && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (retire) begin
        instr_count <= instr_count + CNT_ONE;
      end
      if (set_illegal) begin
        illegal <= 1'b1;
      end
      if (nxt_st == ST_HALT) begin
        halted <= 1'b1;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Strobes are forced low while reset is held so a pending write cannot survive into reset.
  assign ctl_o = RESET ? ctl : '0;

  assign bus.pc_write   = ctl_o.pc_write;
  assign bus.pc_src     = ctl_o.pc_src;
  assign bus.ir_write   = ctl_o.ir_write;
  assign bus.iord       = ctl_o.iord;
  assign bus.mem_read   = ctl_o.mem_read;
  assign bus.mem_write  = ctl_o.mem_write;
  assign bus.reg_write  = ctl_o.reg_write;
  assign bus.reg_dst    = ctl_o.reg_dst;
  assign bus.mem_to_reg = ctl_o.mem_to_reg;
  assign bus.alu_src_a  = ctl_o.alu_src_a;
  assign bus.alu_src_b  = ctl_o.alu_src_b;
  assign bus.alu_op     = ctl_o.alu_op;

  assign state = cur_st;

endmodule
